zxuno_regbank: RTL and testbench
================================

Name: zxuno_regbank

Overview:
- Parametrised successor to the ZX-UNO register-port decoder, on the Z80 I/O bus.
- Keeps the two-port scheme: an address port selects an 8-bit register number, and a data port reads or writes that register.
- Stores the low NREGS registers internally behind a master LOCK bit, and generates single-cycle strobes for all other register numbers.
- Register numbers ≥ NREGS are serviced by external peripherals (SPI, keyboard, mapper).

Parameters:
- IOADDR, 16'hFC3B, I/O address of the register-number port.
- IODATA, 16'hFD3B, I/O address of the register-data port.
- NREGS, 4, number of internally stored registers ($00..NREGS-1). Legal range 1..64.
- RST_REG0, 8'h01, reset value of internal register $00. Reset value of every other internal register is 8'h00.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a  in  16  Z80 address bus.
- iorq_n  in  1  Z80 IORQ, active low.
- rd_n  in  1  Z80 RD, active low.
- wr_n  in  1  Z80 WR, active low.
- din  in  8  CPU data bus into the block.
- dout  out  8  read data to the CPU bus mux.
- oe_n  out  1  low while dout is valid.
- ext_din  in  8  read data from the external register addressed by addr.
- addr  out  8  current register number.
- regs_flat  out  NREGS*8  internal registers, concatenated; reg k is at bits [8k+7:8k].
- read_from_reg  out  1  one-cycle pulse: data-port read started.
- write_to_reg  out  1  one-cycle pulse: data-port write started (external regs only).
- regaddr_changed  out  1  one-cycle pulse: address-port write started.
- locked  out  1  copy of reg $00 bit 7.

Behaviour:
- Access decode (combinational):
  - wa = !iorq_n & !wr_n & a==IOADDR; ra = same with !rd_n.
  - wd = !iorq_n & !wr_n & a==IODATA; rd = same with !rd_n.
- Each of wa, ra, wd, rd is registered each clk (prev flags, reset to 0). Its start pulse is X & !X_prev.
  - Exactly one start pulse per bus access, whatever the number of wait cycles.
- regaddr_changed: start pulse of wa, combinational, 1 cycle wide. On that edge raddr <= din.
- read_from_reg: start pulse of rd, for any register number.
- write_to_reg: start pulse of wd, only when raddr ≥ NREGS. Writes to internal registers raise no strobe.
- Internal write: on the wd start edge with raddr < NREGS and locked==0, reg[raddr] <= din.
  - While locked==1, every internal write is discarded, including the write to $00 itself.
  - LOCK clears only on rst_n.
- dout/oe_n (combinational), oe_n = !(ra | rd):
  - ra: dout = raddr.
  - rd and raddr < NREGS: dout = reg[raddr].
  - rd and raddr ≥ NREGS: dout = ext_din.
  - Otherwise dout = 8'h00, oe_n = 1. No tri-state.
- addr = raddr at all times. An address write is visible on addr from the cycle after the start pulse.
- Reset (async, any cycle, including mid-access):
  - raddr = 0; reg0 = RST_REG0; other regs = 0; prev flags = 0.
  - All strobes 0; oe_n = 1; dout = 0; locked = 0.
- Reset released while an access is still active: the access raises a start pulse on the first clk edge after release.
- iorq_n low with both rd_n and wr_n low: both decodes true. Read and write strobes may both pulse; the write takes effect and dout shows the pre-write value.
- A byte written to IOADDR is stored unmodified; all 8 bits are significant.

Optional Feature:
- Macro: ZXUNO_REGBANK_AUTOINC_EN.
- Defined: raddr increments by 1 (8-bit wrap, $FF -> $00) on the clk edge where a data-port access ends, i.e. rd or wd was 1 on the previous cycle and is 0 now.
  - The increment happens whether the target is internal or external, and whether LOCK is set or not.
  - regaddr_changed does not pulse on an increment.
  - If an address-port write starts on the same edge, the written value wins.
- Not defined: raddr changes only on address-port writes.

Test Plan:
- Reset mid-access: wa held with din=$05, rst_n low for 3 clk -> raddr=$00, reg0=$01, oe_n=1. On release with wa still asserted -> exactly one regaddr_changed pulse, raddr=$05.
- Address write with 3 wait cycles, din=$02, then IODATA write $A5 -> one regaddr_changed pulse, regs_flat[23:16]=$A5, write_to_reg stays 0. IODATA read -> dout=$A5, oe_n=0, one read_from_reg pulse.
- raddr=$04, IODATA write $3C -> write_to_reg pulses exactly once while wr_n is low for 4 cycles, regs_flat unchanged. ext_din=$77 on IODATA read -> dout=$77.
- Lock: write $80 to reg $00 -> locked=1. Write $00 to reg $00 and $11 to reg $01 -> both unchanged. rst_n pulse -> locked=0, reg0=$01.
- IOADDR read after writing $FE -> dout=$FE. Idle bus -> dout=$00, oe_n=1. IOADDR on a read with iorq_n high -> no decode.
- Autoinc built: raddr=$FF, two IODATA reads -> raddr $FF->$00->$01. Autoinc not built: raddr stays $FF.

Source files
------------

// File: rtl/zxuno_regbank.sv
// ZX-UNO style two-port register bank: address port selects a register, data port accesses it.
// Optional build macro ZXUNO_REGBANK_AUTOINC_EN: auto-increment register number after each data access.
module zxuno_regbank #(
  parameter logic [15:0] IOADDR   = 16'hFC3B,
  parameter logic [15:0] IODATA   = 16'hFD3B,
  parameter int          NREGS    = 4,
  parameter logic [7:0]  RST_REG0 = 8'h01
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        a,
  input  logic               iorq_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               oe_n,
  input  logic [7:0]         ext_din,
  output logic [7:0]         addr,
  output logic [NREGS*8-1:0] regs_flat,
  output logic               read_from_reg,
  output logic               write_to_reg,
  output logic               regaddr_changed,
  output logic               locked
);

  logic       wa_s, ra_s, wd_s, rd_s;
  logic       wa_prev_r, ra_prev_r, wd_prev_r, rd_prev_r;
  logic       wa_start_s, wd_start_s, rd_start_s;
  logic       is_int_s, int_wr_s;
  logic [7:0] raddr_r;
  logic [7:0] int_rdata_s;
  logic [7:0] regs_r [NREGS];

  // Decodes are forced off while reset is asserted so strobes and oe_n stay quiet.
  assign wa_s = rst_n & ~iorq_n & ~wr_n & (a == IOADDR);
  assign ra_s = rst_n & ~iorq_n & ~rd_n & (a == IOADDR);
  assign wd_s = rst_n & ~iorq_n & ~wr_n & (a == IODATA);
  assign rd_s = rst_n & ~iorq_n & ~rd_n & (a == IODATA);

  assign wa_start_s = wa_s & ~wa_prev_r;
  assign wd_start_s = wd_s & ~wd_prev_r;
  assign rd_start_s = rd_s & ~rd_prev_r;

  assign is_int_s = ({1'b0, raddr_r} < 9'(NREGS));
  assign locked   = regs_r[0][7];
  assign int_wr_s = wd_start_s & is_int_s & ~locked;

  assign regaddr_changed = wa_start_s;
  assign read_from_reg   = rd_start_s;
  assign write_to_reg    = wd_start_s & ~is_int_s;
  assign addr            = raddr_r;
  assign oe_n            = ~(ra_s | rd_s);

`ifdef ZXUNO_REGBANK_AUTOINC_EN
  logic data_end_s;
  assign data_end_s = (rd_prev_r & ~rd_s) | (wd_prev_r & ~wd_s);
`endif

  // Access edge detectors and the current register number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_prev_r <= 1'b0;
      ra_prev_r <= 1'b0;
      wd_prev_r <= 1'b0;
      rd_prev_r <= 1'b0;
      raddr_r   <= 8'h00;
    end else begin
      wa_prev_r <= wa_s;
      ra_prev_r <= ra_s;
      wd_prev_r <= wd_s;
      rd_prev_r <= rd_s;
      if (wa_start_s) begin
        raddr_r <= din;
`ifdef ZXUNO_REGBANK_AUTOINC_EN
      end else if (data_end_s) begin
        raddr_r <= raddr_r + 8'd1;
`endif
      end
    end
  end

  // Internal register file; LOCK (reg 0 bit 7) freezes it until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_r[k] <= (k == 0) ? RST_REG0 : 8'h00;
      end
    end else if (int_wr_s) begin
      for (int k = 0; k < NREGS; k++) begin
        if (raddr_r == 8'(k)) begin
          regs_r[k] <= din;
        end
      end
    end
  end

  // Mux the addressed internal register without indexing past the array.
  always_comb begin
    int_rdata_s = 8'h00;
    for (int k = 0; k < NREGS; k++) begin
      int_rdata_s = int_rdata_s | (regs_r[k] & {8{raddr_r == 8'(k)}});
    end
  end

  // CPU read data: register number, internal register or external peripheral.
  always_comb begin
    if (ra_s) begin
      dout = raddr_r;
    end else if (rd_s) begin
      dout = is_int_s ? int_rdata_s : ext_din;
    end else begin
      dout = 8'h00;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_r[g];
  end

endmodule

// File: tb/tb_zxuno_regbank.sv
// Directed self-checking bench for zxuno_regbank with default parameters.
module tb_zxuno_regbank;

  localparam logic [15:0] IOADDR = 16'hFC3B;
  localparam logic [15:0] IODATA = 16'hFD3B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic        iorq_n, rd_n, wr_n;
  logic [7:0]  din, ext_din;
  logic [7:0]  dout, addr;
  logic        oe_n, read_from_reg, write_to_reg, regaddr_changed, locked;
  logic [31:0] regs_flat;

  int checks = 0;
  int errors = 0;
  int n_rac = 0;
  int n_rfr = 0;
  int n_wtr = 0;
  int snap_rac, snap_rfr, snap_wtr;
  logic [31:0] snap_regs;
  logic [7:0]  rdv;
  logic        rdoe;

  zxuno_regbank dut (
    .clk(clk), .rst_n(rst_n), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .din(din), .dout(dout), .oe_n(oe_n), .ext_din(ext_din), .addr(addr),
    .regs_flat(regs_flat), .read_from_reg(read_from_reg), .write_to_reg(write_to_reg),
    .regaddr_changed(regaddr_changed), .locked(locked)
  );

  always #5 clk = ~clk;

  // Strobe counters sampled mid-cycle.
  always @(negedge clk) begin
    if (regaddr_changed === 1'b1) n_rac++;
    if (read_from_reg === 1'b1) n_rfr++;
    if (write_to_reg === 1'b1) n_wtr++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic snap();
    snap_rac = n_rac;
    snap_rfr = n_rfr;
    snap_wtr = n_wtr;
  endtask

  task automatic io_write(input logic [15:0] ad, input logic [7:0] d, input int waits);
    @(posedge clk); #1;
    a = ad; din = d; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (1 + waits) @(posedge clk);
    #1;
    iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic io_read(input logic [15:0] ad, input int waits, output logic [7:0] d, output logic oe);
    @(posedge clk); #1;
    a = ad; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    d = dout; oe = oe_n;
    repeat (1 + waits) @(posedge clk);
    #1;
    iorq_n = 1'b1; rd_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; a = 16'h0000; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    din = 8'h00; ext_din = 8'h00;

    // Reset held while an address-port write is active.
    #1; a = IOADDR; din = 8'h05; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_addr", 32'(addr), 32'h00);
    check_eq("rst_regs", regs_flat, 32'h0000_0001);
    check_eq("rst_oe_n", 32'(oe_n), 32'h1);
    check_eq("rst_dout", 32'(dout), 32'h00);
    check_eq("rst_locked", 32'(locked), 32'h0);
    check_eq("rst_strobe", 32'(regaddr_changed), 32'h0);
    snap();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1; iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_pulses", 32'(n_rac - snap_rac), 32'd1);
    check_eq("rel_addr", 32'(addr), 32'h05);

    // Address write with waits, then internal data write and read.
    snap();
    io_write(IOADDR, 8'h02, 3);
    check_eq("aw_pulses", 32'(n_rac - snap_rac), 32'd1);
    check_eq("aw_addr", 32'(addr), 32'h02);
    snap();
    io_write(IODATA, 8'hA5, 0);
    check_eq("int_wr_reg2", 32'(regs_flat[23:16]), 32'hA5);
    check_eq("int_wr_nostrobe", 32'(n_wtr - snap_wtr), 32'd0);
    io_write(IOADDR, 8'h02, 0);
    snap();
    io_read(IODATA, 1, rdv, rdoe);
    check_eq("int_rd_dout", 32'(rdv), 32'hA5);
    check_eq("int_rd_oe_n", 32'(rdoe), 32'h0);
    check_eq("int_rd_pulse", 32'(n_rfr - snap_rfr), 32'd1);

    // External register write and read.
    io_write(IOADDR, 8'h04, 0);
    snap_regs = regs_flat;
    snap();
    io_write(IODATA, 8'h3C, 3);
    check_eq("ext_wr_pulse", 32'(n_wtr - snap_wtr), 32'd1);
    check_eq("ext_wr_regs", regs_flat, snap_regs);
    ext_din = 8'h77;
    io_write(IOADDR, 8'h04, 0);
    io_read(IODATA, 0, rdv, rdoe);
    check_eq("ext_rd_dout", 32'(rdv), 32'h77);

    // LOCK behaviour.
    io_write(IOADDR, 8'h00, 0);
    io_write(IODATA, 8'h80, 0);
    check_eq("lock_set", 32'(locked), 32'h1);
    io_write(IOADDR, 8'h00, 0);
    io_write(IODATA, 8'h00, 0);
    io_write(IOADDR, 8'h01, 0);
    io_write(IODATA, 8'h11, 0);
    check_eq("lock_reg0", 32'(regs_flat[7:0]), 32'h80);
    check_eq("lock_reg1", 32'(regs_flat[15:8]), 32'h00);
    check_eq("lock_still", 32'(locked), 32'h1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("unlock", 32'(locked), 32'h0);
    check_eq("unlock_reg0", 32'(regs_flat[7:0]), 32'h01);
    check_eq("unlock_reg2", 32'(regs_flat[23:16]), 32'h00);

    // Address port readback, idle bus, IORQ high.
    io_write(IOADDR, 8'hFE, 0);
    io_read(IOADDR, 0, rdv, rdoe);
    check_eq("ra_dout", 32'(rdv), 32'hFE);
    check_eq("ra_oe_n", 32'(rdoe), 32'h0);
    @(negedge clk);
    check_eq("idle_dout", 32'(dout), 32'h00);
    check_eq("idle_oe_n", 32'(oe_n), 32'h1);
    a = IOADDR; rd_n = 1'b0;
    @(negedge clk);
    check_eq("noiorq_oe_n", 32'(oe_n), 32'h1);
    check_eq("noiorq_dout", 32'(dout), 32'h00);
    rd_n = 1'b1;

    // Simultaneous RD and WR on the data port: pre-write value shown.
    io_write(IOADDR, 8'h02, 0);
    snap();
    @(posedge clk); #1;
    a = IODATA; din = 8'h5A; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    check_eq("rw_dout", 32'(dout), 32'h00);
    @(posedge clk); #1;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rw_reg2", 32'(regs_flat[23:16]), 32'h5A);
    check_eq("rw_rd_pulse", 32'(n_rfr - snap_rfr), 32'd1);

    // Auto-increment with wrap (or no movement when not built).
    io_write(IOADDR, 8'hFF, 0);
    snap();
    io_read(IODATA, 0, rdv, rdoe);
`ifdef ZXUNO_REGBANK_AUTOINC_EN
    check_eq("inc_addr1", 32'(addr), 32'h00);
`else
    check_eq("inc_addr1", 32'(addr), 32'hFF);
`endif
    io_read(IODATA, 0, rdv, rdoe);
`ifdef ZXUNO_REGBANK_AUTOINC_EN
    check_eq("inc_addr2", 32'(addr), 32'h01);
`else
    check_eq("inc_addr2", 32'(addr), 32'hFF);
`endif
    check_eq("inc_no_rac", 32'(n_rac - snap_rac), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
